// File: rtl/wave_renderer_if.sv
// wave_renderer_if: xvga timing inputs, scroll controls and rendered pixel/sync outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; one pixel per vclock in both directions.
interface wave_renderer_if;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync;
   logic        vsync;
   logic        blank;
   logic [3:0]  speed;
   logic [1:0]  amp;
   logic [11:0] pixel;
   logic        phsync;
   logic        pvsync;
   logic        pblank;

   // Timing/control source side.
   modport master (
      output hcount, vcount, hsync, vsync, blank, speed, amp,
      input  pixel, phsync, pvsync, pblank
   );

   // Renderer side.
   modport slave (
      input  hcount, vcount, hsync, vsync, blank, speed, amp,
      output pixel, phsync, pvsync, pblank
   );
endinterface

// File: rtl/wave_renderer.sv
// wave_renderer: scrolling sine wave (sky/line/water) behind xvga; build macro WAVE_GRID_EN adds a sky grid.
// Latency: 3 vclock cycles for pixel, phsync, pvsync and pblank.
// Backpressure: none; a new pixel is accepted on every vclock.
module wave_renderer #(
   parameter int          BASELINE    = 384,
   parameter int          THICK       = 2,
   parameter logic [11:0] SKY_COLOR   = 12'h8CF,
   parameter logic [11:0] WAVE_COLOR  = 12'hFFF,
   parameter logic [11:0] WATER_COLOR = 12'h04A
) (
   input logic            vclock,
   input logic            reset,
   wave_renderer_if.slave bus
);

   localparam logic signed [10:0] BASE_S     = 11'(BASELINE);
   localparam logic signed [10:0] THICK_M1   = 11'(THICK - 1);
`ifdef WAVE_GRID_EN
   localparam logic [11:0]        GRID_COLOR = 12'h888;
`endif

   // Quarter-wave table: round(127*sin(pi*(2a+1)/256)), a = 0..63.
   function automatic logic [6:0] quarter_sine(input logic [5:0] a);
      logic [6:0] v;
      v = 7'd0;
      case (a)
         6'd0:  v = 7'd2;   6'd1:  v = 7'd5;   6'd2:  v = 7'd8;   6'd3:  v = 7'd11;
         6'd4:  v = 7'd14;  6'd5:  v = 7'd17;  6'd6:  v = 7'd20;  6'd7:  v = 7'd23;
         6'd8:  v = 7'd26;  6'd9:  v = 7'd29;  6'd10: v = 7'd32;  6'd11: v = 7'd35;
         6'd12: v = 7'd38;  6'd13: v = 7'd41;  6'd14: v = 7'd44;  6'd15: v = 7'd47;
         6'd16: v = 7'd50;  6'd17: v = 7'd53;  6'd18: v = 7'd56;  6'd19: v = 7'd58;
         6'd20: v = 7'd61;  6'd21: v = 7'd64;  6'd22: v = 7'd67;  6'd23: v = 7'd69;
         6'd24: v = 7'd72;  6'd25: v = 7'd74;  6'd26: v = 7'd77;  6'd27: v = 7'd79;
         6'd28: v = 7'd82;  6'd29: v = 7'd84;  6'd30: v = 7'd86;  6'd31: v = 7'd89;
         6'd32: v = 7'd91;  6'd33: v = 7'd93;  6'd34: v = 7'd95;  6'd35: v = 7'd97;
         6'd36: v = 7'd99;  6'd37: v = 7'd101; 6'd38: v = 7'd103; 6'd39: v = 7'd105;
         6'd40: v = 7'd106; 6'd41: v = 7'd108; 6'd42: v = 7'd110; 6'd43: v = 7'd111;
         6'd44: v = 7'd113; 6'd45: v = 7'd114; 6'd46: v = 7'd115; 6'd47: v = 7'd117;
         6'd48: v = 7'd118; 6'd49: v = 7'd119; 6'd50: v = 7'd120; 6'd51: v = 7'd121;
         6'd52: v = 7'd122; 6'd53: v = 7'd123; 6'd54: v = 7'd124; 6'd55: v = 7'd124;
         6'd56: v = 7'd125; 6'd57: v = 7'd125; 6'd58: v = 7'd126; 6'd59: v = 7'd126;
         default: v = 7'd127;
      endcase
      return v;
   endfunction

   // hcount >= 1024 only occurs during blanking, so the MSB is ignored.
   logic unused_hcount_msb;
   assign unused_hcount_msb = bus.hcount[10];

   logic [9:0] phase;
   logic       vsync_d;

   // Advance the scroll phase once per frame, on the vsync rising edge.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         phase   <= 10'd0;
         vsync_d <= 1'b0;
      end else begin
         vsync_d <= bus.vsync;
         if (bus.vsync && !vsync_d)
            phase <= phase + {6'd0, bus.speed};
      end
   end

   // The wave period is 256 columns, so only the low 8 bits of hcount+phase matter.
   logic [7:0] idx;
   assign idx = bus.hcount[7:0] + phase[7:0];

   logic [7:0] s1_idx;
   logic [9:0] s1_vcount;
   logic       s1_hsync, s1_vsync, s1_blank;
`ifdef WAVE_GRID_EN
   logic       s1_hzero, s2_hzero;
`endif

   // S1: register the wave index alongside the timing fields.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         s1_idx    <= 8'd0;
         s1_vcount <= 10'd0;
         s1_hsync  <= 1'b0;
         s1_vsync  <= 1'b0;
         s1_blank  <= 1'b1;
`ifdef WAVE_GRID_EN
         s1_hzero  <= 1'b0;
`endif
      end else begin
         s1_idx    <= idx;
         s1_vcount <= bus.vcount;
         s1_hsync  <= bus.hsync;
         s1_vsync  <= bus.vsync;
         s1_blank  <= bus.blank;
`ifdef WAVE_GRID_EN
         s1_hzero  <= (bus.hcount[5:0] == 6'd0);
`endif
      end
   end

   // Quadrant folding: odd quadrants mirror the address, upper half negates.
   logic [1:0]        quad;
   logic [5:0]        addr;
   logic [6:0]        mag;
   logic signed [7:0] s_raw, s_shifted;
   assign quad      = s1_idx[7:6];
   assign addr      = quad[0] ? ~s1_idx[5:0] : s1_idx[5:0];
   assign mag       = quarter_sine(addr);
   assign s_raw     = quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
   assign s_shifted = s_raw >>> bus.amp;

   logic signed [7:0] s2_s;
   logic [9:0]        s2_vcount;
   logic              s2_hsync, s2_vsync, s2_blank;

   // S2: register the attenuated sample with the delayed timing fields.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         s2_s      <= 8'sd0;
         s2_vcount <= 10'd0;
         s2_hsync  <= 1'b0;
         s2_vsync  <= 1'b0;
         s2_blank  <= 1'b1;
`ifdef WAVE_GRID_EN
         s2_hzero  <= 1'b0;
`endif
      end else begin
         s2_s      <= s_shifted;
         s2_vcount <= s1_vcount;
         s2_hsync  <= s1_hsync;
         s2_vsync  <= s1_vsync;
         s2_blank  <= s1_blank;
`ifdef WAVE_GRID_EN
         s2_hzero  <= s1_hzero;
`endif
      end
   end

   // Signed 11-bit line position; vcount is zero-extended so the compare is exact.
   logic signed [10:0] y_top, y_bot, v_s;
   assign y_top = BASE_S - {{3{s2_s[7]}}, s2_s};
   assign y_bot = y_top + THICK_M1;
   assign v_s   = $signed({1'b0, s2_vcount});

   logic [11:0] color;

   // S3 region select: blank, sky above the line, the line itself, water below.
   always_comb begin
      color = WATER_COLOR;
      if (s2_blank) begin
         color = 12'h000;
      end else if (v_s < y_top) begin
`ifdef WAVE_GRID_EN
         color = ((s2_vcount[5:0] == 6'd0) || s2_hzero) ? GRID_COLOR : SKY_COLOR;
`else
         color = SKY_COLOR;
`endif
      end else if (v_s <= y_bot) begin
         color = WAVE_COLOR;
      end
   end

   // S3: output registers, syncs and blank aligned with the pixel.
   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         bus.pixel  <= 12'h000;
         bus.phsync <= 1'b0;
         bus.pvsync <= 1'b0;
         bus.pblank <= 1'b1;
      end else begin
         bus.pixel  <= color;
         bus.phsync <= s2_hsync;
         bus.pvsync <= s2_vsync;
         bus.pblank <= s2_blank;
      end
   end

endmodule

// File: tb/tb_wave_renderer.sv
// tb_wave_renderer: directed stimulus for wave_renderer, checked every cycle against a behavioural model.
// Latency: the model expects each input cycle's result three vclock edges later.
// Backpressure: none.
module tb_wave_renderer;

   typedef struct packed {
      logic [11:0] pix;
      logic        hs;
      logic        vs;
      logic        bl;
   } out_t;

   localparam out_t RST_OUT = '{pix: 12'h000, hs: 1'b0, vs: 1'b0, bl: 1'b1};
   localparam real  PI      = 3.14159265358979323846;

   logic vclock = 1'b0;
   logic reset  = 1'b1;
   wave_renderer_if bus();

   wave_renderer dut (
      .vclock (vclock),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 vclock = ~vclock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Pixel from first principles: a 256-column sine sampled at column centres.
   function automatic out_t model_out(input logic [10:0] h, input logic [9:0] v,
                                      input logic hs, input logic vs, input logic bl,
                                      input logic [9:0] ph, input logic [1:0] am);
      out_t o;
      int   col, s, ss, y, vi;
      real  r;
      col = ((int'(h) % 1024) + int'(ph)) % 256;
      r   = 127.0 * $sin(2.0 * PI * (real'(col) + 0.5) / 256.0);
      s   = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
      ss  = $rtoi($floor(real'(s) / real'(1 << am)));
      y   = 384 - ss;
      vi  = int'(v);
      o.hs = hs;
      o.vs = vs;
      o.bl = bl;
      if (bl)
         o.pix = 12'h000;
      else if (vi < y) begin
         o.pix = 12'h8CF;
`ifdef WAVE_GRID_EN
         if ((vi % 64 == 0) || (int'(h) % 64 == 0))
            o.pix = 12'h888;
`endif
      end else if (vi <= y + 1)
         o.pix = 12'hFFF;
      else
         o.pix = 12'h04A;
      return o;
   endfunction

   out_t       exp_q[$];
   logic [9:0] m_phase;
   logic       m_vs_prev;

   // Model: queue expected outputs per accepted cycle, track the frame phase.
   always @(posedge vclock or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         exp_q.push_back(RST_OUT);
         exp_q.push_back(RST_OUT);
         exp_q.push_back(RST_OUT);
         m_phase   <= 10'd0;
         m_vs_prev <= 1'b0;
      end else begin
         exp_q.push_back(model_out(bus.hcount, bus.vcount, bus.hsync, bus.vsync,
                                   bus.blank, m_phase, bus.amp));
         if (exp_q.size() > 3)
            void'(exp_q.pop_front());
         if (bus.vsync && !m_vs_prev)
            m_phase <= 10'((int'(m_phase) + int'(bus.speed)) % 1024);
         m_vs_prev <= bus.vsync;
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge vclock) begin
      if (exp_q.size() == 3)
         check("stream", {1'b0, bus.pixel, bus.phsync, bus.pvsync, bus.pblank},
               {1'b0, exp_q[0].pix, exp_q[0].hs, exp_q[0].vs, exp_q[0].bl});
   end

   task automatic step(input int h, input int v, input logic hs, input logic vs, input logic bl);
      bus.hcount = 11'(h);
      bus.vcount = 10'(v);
      bus.hsync  = hs;
      bus.vsync  = vs;
      bus.blank  = bl;
      @(negedge vclock);
   endtask

   task automatic idle();
      step(0, 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic pix_at(input string name, input int h, input int v, input logic [11:0] exp);
      step(h, v, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      check(name, {4'h0, bus.pixel}, {4'h0, exp});
   endtask

   task automatic vs_pulse();
      step(0, 0, 1'b0, 1'b1, 1'b1);
      step(0, 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic set_amp(input logic [1:0] a);
      idle();
      bus.amp = a;
   endtask

   task automatic pulse_reset();
      @(posedge vclock);
      #2 reset = 1'b1;
      @(negedge vclock);
      reset = 1'b0;
   endtask

   initial begin
      bus.speed = 4'd0;
      bus.amp   = 2'd0;
      bus.hcount = 11'd0;
      bus.vcount = 10'd0;
      bus.hsync  = 1'b0;
      bus.vsync  = 1'b0;
      bus.blank  = 1'b1;
      repeat (3) @(negedge vclock);
      check("rst_pixel",  {4'h0, bus.pixel}, 16'h0000);
      check("rst_pblank", {15'd0, bus.pblank}, 16'd1);
      reset = 1'b0;

      // Mid-line reset clears everything immediately.
      repeat (4) step(0, 382, 1'b1, 1'b1, 1'b0);
      check("pre_rst_pixel", {4'h0, bus.pixel}, 16'h0FFF);
      @(posedge vclock);
      #2 reset = 1'b1;
      #1;
      check("midrst_pixel",  {4'h0, bus.pixel}, 16'h0000);
      check("midrst_pblank", {15'd0, bus.pblank}, 16'd1);
      check("midrst_phsync", {15'd0, bus.phsync}, 16'd0);
      check("midrst_pvsync", {15'd0, bus.pvsync}, 16'd0);
      bus.vsync = 1'b0;
      bus.hsync = 1'b0;
      bus.blank = 1'b1;
      @(negedge vclock);
      reset = 1'b0;

      // Phase 0, full amplitude.
      pix_at("h0_v382",   0,   382, 12'hFFF);
      pix_at("h0_v381",   0,   381, 12'h8CF);
      pix_at("h0_v383",   0,   383, 12'hFFF);
      pix_at("h0_v384",   0,   384, 12'h04A);
      pix_at("h64_v257",  64,  257, 12'hFFF);
      pix_at("h64_v256",  64,  256, 12'h8CF);
      pix_at("h192_v511", 192, 511, 12'hFFF);
      pix_at("h192_v512", 192, 512, 12'hFFF);
      pix_at("h192_v513", 192, 513, 12'h04A);

      // Attenuation.
      set_amp(2'd2);
      pix_at("amp2_v353", 64, 353, 12'hFFF);
      pix_at("amp2_v352", 64, 352, 12'h8CF);
      pix_at("amp2_neg",  192, 416, 12'hFFF);
      set_amp(2'd3);
      pix_at("amp3_v369", 64, 369, 12'hFFF);
      set_amp(2'd0);

      // Full-line sweeps across the wave band, model-checked every cycle.
      for (int k = 0; k < 5; k++) begin
         int vl;
         vl = (k == 0) ? 260 : (k == 1) ? 380 : (k == 2) ? 383 : (k == 3) ? 450 : 505;
         if (k == 3) set_amp(2'd1);
         for (int h = 0; h < 1056; h++)
            step(h, vl, (h >= 1030 && h < 1040), 1'b0, (h >= 1024));
      end
      set_amp(2'd0);

      // Phase accumulation.
      pix_at("ph0_h52", 52, 257, 12'h8CF);
      bus.speed = 4'd4;
      repeat (3) vs_pulse();
      pix_at("ph12_h52", 52, 257, 12'hFFF);
      bus.speed = 4'd8;
      repeat (126) vs_pulse();
      pix_at("ph1020_h68", 68, 257, 12'hFFF);
      vs_pulse();
      pix_at("ph4_h60", 60, 257, 12'hFFF);
      bus.speed = 4'd0;
      repeat (5) vs_pulse();
      pix_at("frozen_h60", 60, 257, 12'hFFF);
      pix_at("frozen_h64", 64, 257, 12'h8CF);

      // Blanking and sync alignment.
      step(0, 382, 1'b0, 1'b0, 1'b1);
      idle();
      idle();
      check("blank_pixel", {4'h0, bus.pixel}, 16'h0000);
      step(0, 0, 1'b1, 1'b1, 1'b0);
      idle();
      check("sync_early", {13'd0, bus.phsync, bus.pvsync, bus.pblank}, 16'd1);
      idle();
      check("sync_lat3", {13'd0, bus.phsync, bus.pvsync, bus.pblank}, 16'd6);
      for (int i = 0; i < 48; i++)
         step((i * 37) % 1024, 380 + (i % 6), (i % 3 == 1), (i % 5 >= 3),
              (i % 4 == 0) || (i % 7 == 2));
      repeat (3) idle();

`ifdef WAVE_GRID_EN
      pulse_reset();
      pix_at("grid_h128", 128, 100, 12'h888);
      pix_at("grid_h129", 129, 100, 12'h8CF);
      pix_at("grid_v64",  129, 64,  12'h888);
      pix_at("grid_water", 0,  400, 12'h04A);
`else
      pulse_reset();
      pix_at("sky_h128", 128, 100, 12'h8CF);
      pix_at("sky_v64",  129, 64,  12'h8CF);
`endif
      repeat (4) idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wave_renderer.md
Name: wave_renderer

Overview:
- Pixel-generation stage that sits directly downstream of the xvga timing generator in the 1024x768 @ 65 MHz video path.
- Consumes hcount, vcount, hsync, vsync and blank, and produces a 12-bit RGB pixel plus sync/blank delayed to match.
- Draws a scrolling sine wave: sky above the wave line, water below it.
- The phase advances once per frame, so the wave scrolls horizontally.

Parameters:
- BASELINE, 384: vertical centre line of the wave, in pixels.
- THICK, 2: wave line thickness, in rows.
- SKY_COLOR, 12'h8CF: RGB444 colour above the wave.
- WAVE_COLOR, 12'hFFF: RGB444 colour of the wave line.
- WATER_COLOR, 12'h04A: RGB444 colour below the wave.

Ports:
- vclock  in  1  65 MHz pixel clock
- reset  in  1  asynchronous, active-high reset
- hcount  in  11  horizontal pixel count from xvga
- vcount  in  10  vertical line count from xvga
- hsync  in  1  active-high hsync from xvga
- vsync  in  1  active-high vsync from xvga
- blank  in  1  high outside the visible area
- speed  in  4  phase increment per frame, in pixels (0 = frozen)
- amp  in  2  amplitude attenuation (right-shift count, 0..3)
- pixel  out  12  {R[3:0], G[3:0], B[3:0]}
- phsync  out  1  hsync delayed by 3 cycles
- pvsync  out  1  vsync delayed by 3 cycles
- pblank  out  1  blank delayed by 3 cycles

Behaviour:
- Clock and reset:
  - Single clock, vclock.
  - reset is asynchronous, active-high.
  - Reset values: pixel=0, phsync=0, pvsync=0, pblank=1, phase=0, vsync_d=0, and all pipeline registers cleared with the blank stage set to 1.
  - Asserting reset mid-frame takes effect immediately. Output resumes 3 cycles after reset deasserts.
- Phase accumulator:
  - 10-bit register `phase`.
  - vsync_d is vsync registered once.
  - On a vsync rising edge (vsync=1, vsync_d=0): phase <= phase + speed, modulo 1024. speed is sampled on that same cycle.
  - phase changes at no other time.
- Pipeline, fixed latency of exactly 3 cycles for pixel, phsync, pvsync and pblank:
  - S1: idx = hcount[9:0] + phase, modulo 1024. Register idx[7:0], vcount, hsync, vsync, blank.
  - S2: quadrant q = idx[7:6], address a = idx[5:0].
    - Quarter-wave LUT: Q(a) = round(127*sin(pi*(2a+1)/256)) for a = 0..63. This gives Q(0)=2 and Q(63)=127.
    - q=0 -> s=+Q(a); q=1 -> s=+Q(63-a); q=2 -> s=-Q(a); q=3 -> s=-Q(63-a).
    - s is signed 8-bit. Register s >>> amp (arithmetic shift) together with the delayed S1 fields.
  - S3: y = BASELINE - s_shifted, computed in signed 11-bit.
    - blank=1 -> pixel=0.
    - vcount < y -> SKY_COLOR.
    - y <= vcount <= y+THICK-1 -> WAVE_COLOR.
    - Otherwise -> WATER_COLOR.
    - Register the result together with the delayed syncs and blank.
- Wave geometry: period is 256 pixels horizontally; waveform repeats 4 times across 1024 columns.
- Boundaries:
  - Only hcount[9:0] is used, so values of 1024 and above wrap; they occur only while blank=1.
  - vcount is compared as unsigned zero-extended.
  - y always lies within 257..511 for the default BASELINE, so no clipping is required.
  - A vsync edge that coincides with visible pixels cannot occur with xvga timing. If it did, the new phase would apply from the next S1 cycle.

Optional Feature:
- Macro: WAVE_GRID_EN.
- Defined:
  - In the S3 sky region only, pixel = 12'h888 when vcount[5:0]==0 or (hcount[5:0]==0, delayed to S3).
  - Wave and water regions are unchanged.
  - Latency stays at 3.
- Undefined: no grid logic is synthesized; the sky is solid SKY_COLOR.

Test Plan:
- Reset pulse mid-line -> pixel=0, pblank=1, phsync=0, pvsync=0 immediately. After release with phase=0, amp=0:
  - hcount=0, vcount=382 -> pixel=12'hFFF exactly 3 cycles later.
  - vcount=381 -> 12'h8CF.
  - vcount=384 -> 12'h04A.
- phase=0, amp=0:
  - hcount=64 (Q(63)=127, y=257): vcount=257 -> 12'hFFF; vcount=256 -> 12'h8CF.
  - hcount=192 (s=-127, y=511): vcount=511 -> 12'hFFF; vcount=513 -> 12'h04A.
- amp=2, hcount=64: y = 384 - 31 = 353, so vcount=353 -> 12'hFFF.
  - amp=3: y = 384 - 15 = 369, so vcount=369 -> 12'hFFF.
- speed=4 with 3 vsync rising edges -> phase=12. Then speed=8 from phase=1020 -> phase=4 after one edge. speed=0 -> phase unchanged across 5 frames.
- blank=1 with any hcount/vcount -> pixel=0. hsync, vsync and blank toggle patterns appear on phsync, pvsync and pblank exactly 3 cycles later, with no dropped or extra edges.
- With WAVE_GRID_EN: phase=0, amp=0, hcount=128, vcount=100 -> 12'h888; hcount=129, vcount=100 -> 12'h8CF; hcount=0, vcount=400 -> 12'h04A.
